// File: rtl/gate_resp_misr.sv
// gate_resp_misr: folds one WIDTH-bit model response per handshake into a
// SIG_W-bit MISR, then compares the final signature with a golden value.
//
// Ports
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   start         begin a run; honoured in IDLE and DONE only
//   abort         cancel the run from any state, back to IDLE
//   num_patterns  beats in this run, sampled on start
//   expected_sig  golden signature, sampled on start
//   resp_valid    resp_data holds a settled model response
//   resp_data     model outputs, LSB = first output
//   resp_ready    beat accepted this cycle (decoded from state)
//   busy / done   high in RUN / DONE
//   pass          signature matched expected_sig; meaningful while done
//   signature     current MISR contents
//   count         beats accepted in the current run
module gate_resp_misr #(
    parameter int unsigned          WIDTH = 10,
    parameter int unsigned          SIG_W = 16,
    parameter logic [SIG_W-1:0]     POLY  = 16'h1021,
    parameter logic [SIG_W-1:0]     SEED  = 16'hFFFF,
    parameter int unsigned          CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_patterns,
    input  logic [SIG_W-1:0] expected_sig,
    input  logic             resp_valid,
    input  logic [WIDTH-1:0] resp_data,
    output logic             resp_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature,
    output logic [CNT_W-1:0] count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state,   state_n;
    logic [SIG_W-1:0] sig_n;
    logic [CNT_W-1:0] count_n;
    logic [CNT_W-1:0] num_q,   num_n;
    logic [SIG_W-1:0] exp_q,   exp_n;
    logic             pass_n;
    logic [SIG_W-1:0] sig_mix;
    logic [CNT_W-1:0] count_inc;

    // Status flags decode straight from the state register.
    assign resp_ready = (state == ST_RUN);
    assign busy       = (state == ST_RUN);
    assign done       = (state == ST_DONE);

    // MISR step: shift, polynomial feedback on MSB, fold in the response.
    assign sig_mix   = {signature[SIG_W-2:0], 1'b0}
                     ^ (signature[SIG_W-1] ? POLY : '0)
                     ^ SIG_W'(resp_data);
    assign count_inc = count + CNT_W'(1);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            signature <= '0;
            count     <= '0;
            num_q     <= '0;
            exp_q     <= '0;
            pass      <= 1'b0;
        end else begin
            state     <= state_n;
            signature <= sig_n;
            count     <= count_n;
            num_q     <= num_n;
            exp_q     <= exp_n;
            pass      <= pass_n;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_n = state;
        sig_n   = signature;
        count_n = count;
        num_n   = num_q;
        exp_n   = exp_q;
        pass_n  = pass;

        if (abort) begin
            // Abort wins over start and over a same-cycle beat; the beat is dropped.
            state_n = ST_IDLE;
            pass_n  = 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        num_n   = num_patterns;
                        exp_n   = expected_sig;
                        sig_n   = SEED;
                        count_n = '0;
                        if (num_patterns == '0) begin
                            state_n = ST_DONE;
                            pass_n  = (SEED == expected_sig);
                        end else begin
                            state_n = ST_RUN;
                            pass_n  = 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (resp_valid) begin
                        sig_n   = sig_mix;
                        count_n = count_inc;
                        // Last beat: judge the signature that is being written.
                        if (count_inc == num_q) begin
                            state_n = ST_DONE;
                            pass_n  = (sig_mix == exp_q);
                        end
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    pass_n  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_resp_misr.sv
// Directed bench for gate_resp_misr: single-beat table runs plus hand-written
// multi-beat, zero-pattern, gapped, abort and async-reset sequences.
module tb_gate_resp_misr;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] num_patterns;
    logic [15:0] expected_sig;
    logic        resp_valid;
    logic [9:0]  resp_data;
    logic        resp_ready;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] signature;
    logic [15:0] count;

    int checks = 0;
    int errors = 0;

    gate_resp_misr dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .num_patterns (num_patterns),
        .expected_sig (expected_sig),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .resp_ready   (resp_ready),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .signature    (signature),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  beat;
        logic [15:0] exp_in;
        logic [15:0] sig;
        logic        pass;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the start edge.
    task automatic do_start(input logic [15:0] num, input logic [15:0] exp_sig);
        start        = 1'b1;
        num_patterns = num;
        expected_sig = exp_sig;
        @(negedge clk);
        start        = 1'b0;
    endtask

    task automatic send_beat(input logic [9:0] d);
        resp_valid = 1'b1;
        resp_data  = d;
        check("ready_on_beat", 32'(resp_ready), 32'd1);
        @(negedge clk);
        resp_valid = 1'b0;
    endtask

    task automatic idle_cycle(input logic [9:0] junk);
        resp_valid = 1'b0;
        resp_data  = junk;
        @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{beat: 10'h3FF, exp_in: 16'hEC20, sig: 16'hEC20, pass: 1'b1};
        vecs[1] = '{beat: 10'h000, exp_in: 16'h0000, sig: 16'hEFDF, pass: 1'b0};
        vecs[2] = '{beat: 10'h001, exp_in: 16'hEFDE, sig: 16'hEFDE, pass: 1'b1};
        vecs[3] = '{beat: 10'h200, exp_in: 16'hEDDE, sig: 16'hEDDF, pass: 1'b0};
        vecs[4] = '{beat: 10'h155, exp_in: 16'hEE8A, sig: 16'hEE8A, pass: 1'b1};

        rst_n        = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        num_patterns = '0;
        expected_sig = '0;
        resp_valid   = 1'b0;
        resp_data    = '0;

        // Reset values
        #3;
        check("rst_ready", 32'(resp_ready), 32'd0);
        check("rst_busy",  32'(busy),       32'd0);
        check("rst_done",  32'(done),       32'd0);
        check("rst_pass",  32'(pass),       32'd0);
        check("rst_sig",   32'(signature),  32'h0);
        check("rst_count", 32'(count),      32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1: single beat 3FF, done one cycle after the handshake
        do_start(16'd1, 16'hEC20);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_sig_seed", 32'(signature), 32'hFFFF);
        send_beat(10'h3FF);
        check("t1_done", 32'(done), 32'd1);
        check("t1_busy_off", 32'(busy), 32'd0);
        check("t1_sig", 32'(signature), 32'hEC20);
        check("t1_count", 32'(count), 32'd1);
        check("t1_pass", 32'(pass), 32'd1);

        // Table of single-beat runs, each restarted from DONE
        for (int i = 0; i < 5; i++) begin
            do_start(16'd1, vecs[i].exp_in);
            check("tab_pass_clear", 32'(pass), 32'd0);
            check("tab_count_clear", 32'(count), 32'd0);
            send_beat(vecs[i].beat);
            check("tab_done", 32'(done), 32'd1);
            check("tab_sig", 32'(signature), 32'(vecs[i].sig));
            check("tab_pass", 32'(pass), 32'(vecs[i].pass));
        end

        // Test 2: two zero beats
        do_start(16'd2, 16'hCF9F);
        send_beat(10'h000);
        check("t2_sig1", 32'(signature), 32'hEFDF);
        check("t2_not_done", 32'(done), 32'd0);
        send_beat(10'h000);
        check("t2_sig2", 32'(signature), 32'hCF9F);
        check("t2_done", 32'(done), 32'd1);
        check("t2_pass", 32'(pass), 32'd1);
        idle_cycle(10'h3FF);
        check("t2_hold_sig", 32'(signature), 32'hCF9F);
        check("t2_hold_done", 32'(done), 32'd1);

        // Test 3: zero-pattern run
        do_start(16'd0, 16'hFFFF);
        check("t3_done", 32'(done), 32'd1);
        check("t3_pass", 32'(pass), 32'd1);
        check("t3_count", 32'(count), 32'd0);
        check("t3_ready", 32'(resp_ready), 32'd0);
        check("t3_sig", 32'(signature), 32'hFFFF);
        do_start(16'd0, 16'h1234);
        check("t3b_pass", 32'(pass), 32'd0);

        // Test 4: gapped run, with a start during RUN that must be ignored
        do_start(16'd3, 16'h81B6);
        send_beat(10'h3FF);
        start        = 1'b1;
        num_patterns = 16'd0;
        idle_cycle(10'h2AA);
        start        = 1'b0;
        check("t4_gap_count", 32'(count), 32'd1);
        check("t4_gap_sig", 32'(signature), 32'hEC20);
        check("t4_start_ignored", 32'(busy), 32'd1);
        send_beat(10'h000);
        check("t4_sig2", 32'(signature), 32'hC861);
        idle_cycle(10'h155);
        send_beat(10'h155);
        check("t4_count", 32'(count), 32'd3);
        check("t4_sig", 32'(signature), 32'h81B6);
        check("t4_done", 32'(done), 32'd1);
        check("t4_pass", 32'(pass), 32'd1);
        // Same beats without gaps
        do_start(16'd3, 16'h81B6);
        send_beat(10'h3FF);
        send_beat(10'h000);
        send_beat(10'h155);
        check("t4g_sig", 32'(signature), 32'h81B6);
        check("t4g_pass", 32'(pass), 32'd1);

        // Test 5: abort together with a valid beat
        do_start(16'd3, 16'h0000);
        send_beat(10'h3FF);
        abort      = 1'b1;
        start      = 1'b1;
        resp_valid = 1'b1;
        resp_data  = 10'h000;
        @(negedge clk);
        abort      = 1'b0;
        start      = 1'b0;
        resp_valid = 1'b0;
        check("t5_done", 32'(done), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_ready", 32'(resp_ready), 32'd0);
        check("t5_count", 32'(count), 32'd1);
        check("t5_sig", 32'(signature), 32'hEC20);
        // Abort from DONE clears done and pass
        do_start(16'd0, 16'hFFFF);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t5b_done", 32'(done), 32'd0);
        check("t5b_pass", 32'(pass), 32'd0);

        // Test 6: asynchronous reset mid-run
        do_start(16'd2, 16'h0000);
        send_beat(10'h3FF);
        #2 rst_n = 1'b0;
        #1;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_ready", 32'(resp_ready), 32'd0);
        check("t6_sig", 32'(signature), 32'h0);
        check("t6_count", 32'(count), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_start(16'd1, 16'hEFDF);
        send_beat(10'h000);
        check("t6_after_sig", 32'(signature), 32'hEFDF);
        check("t6_after_done", 32'(done), 32'd1);
        check("t6_after_pass", 32'(pass), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
